// File: rtl/gr_wb_ctrl.sv
// Write-back controller for the GR file: sequences one write-back at a time,
// stalls HI/LO on the MDU and DRr on memory data, with a bounded wait and a stall counter.
module gr_wb_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_req,
  input  logic [2:0]  wb_src,
  input  logic [4:0]  wb_rd,
  output logic        wb_ready,
  input  logic        mem_rdy,
  input  logic        mdu_busy,
  output logic [2:0]  MUX_GR_W_DATA,
  output logic        gr_we,
  output logic [4:0]  gr_waddr,
  output logic        wb_done,
  output logic        wb_err,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] SRC_NONE  = 3'd7;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_src_q;
  logic [4:0]  r_rd_q;
  logic [7:0]  r_wait_cnt;
  logic [15:0] r_stall_cnt;
  logic        w_accept;
  logic        w_wait_inc;

  function automatic logic src_ready(input logic [2:0] src, input logic mem_ok,
                                     input logic busy);
    case (src)
      3'd1:               src_ready = mem_ok;
      3'd2, 3'd3:         src_ready = ~busy;
      3'd0, 3'd4, 3'd5:   src_ready = 1'b1;
      default:            src_ready = 1'b0;
    endcase
  endfunction

  function automatic logic src_illegal(input logic [2:0] src);
    src_illegal = (src == 3'd6) || (src == 3'd7);
  endfunction

  assign w_accept = (r_state == ST_IDLE) && wb_req;

  // Next-state decode; a ready source beats the timeout in the same cycle
  always_comb begin
    w_next     = r_state;
    w_wait_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!wb_req)                                 w_next = ST_IDLE;
        else if (src_illegal(wb_src))                w_next = ST_ERR;
        else if (src_ready(wb_src, mem_rdy, mdu_busy)) w_next = ST_WRITE;
        else                                         w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (src_ready(r_src_q, mem_rdy, mdu_busy))   w_next = ST_WRITE;
        else if (r_wait_cnt == WAIT_LAST)            w_next = ST_ERR;
        else begin
          w_next     = ST_WAIT;
          w_wait_inc = 1'b1;
        end
      end
      ST_WRITE: w_next = ST_IDLE;
      ST_ERR:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Request latch, wait counter and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src_q     <= SRC_NONE;
      r_rd_q      <= 5'd0;
      r_wait_cnt  <= 8'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      if (w_accept) begin
        r_src_q    <= wb_src;
        r_rd_q     <= wb_rd;
        r_wait_cnt <= 8'd0;
      end else if (w_wait_inc) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end else begin
        r_wait_cnt <= r_wait_cnt;
      end
      if ((r_state == ST_WAIT) && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      else
        r_stall_cnt <= r_stall_cnt;
    end
  end

  // Outputs depend only on state and latched request, never on live inputs
  always_comb begin
    wb_ready      = 1'b0;
    MUX_GR_W_DATA = SRC_NONE;
    gr_we         = 1'b0;
    gr_waddr      = 5'd0;
    wb_done       = 1'b0;
    wb_err        = 1'b0;
    case (r_state)
      ST_IDLE: wb_ready = 1'b1;
      ST_WAIT: begin
        MUX_GR_W_DATA = r_src_q;
        gr_waddr      = r_rd_q;
      end
      ST_WRITE: begin
        MUX_GR_W_DATA = r_src_q;
        gr_waddr      = r_rd_q;
        gr_we         = (r_rd_q != 5'd0);
        wb_done       = 1'b1;
      end
      ST_ERR:  wb_err = 1'b1;
      default: wb_ready = 1'b0;
    endcase
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/gr_wb_ctrl.md
# gr_wb_ctrl

Write-back controller for the general-register file in the multi-cycle MIPS core. It accepts one write-back request at a time from the main control FSM and drives the GR write-data mux select, write enable and write address. It holds off HI/LO writes while the multiply/divide unit is busy and DRr writes until memory read data is valid. Stalls are bounded by a timeout, and cumulative stall cycles are counted for performance monitoring.

## Interface
- TIMEOUT_CYCLES, 64: maximum WAIT cycles before a request is aborted with an error; legal range 2..255.
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wb_req  in  1  write-back request from the control FSM
- wb_src  in  3  data source: 0 Z, 1 DRr, 2 HI, 3 LO, 4 PC, 5 CLZ; 6 and 7 are illegal
- wb_rd  in  5  destination register number
- wb_ready  out  1  high in IDLE; a request is accepted on a cycle with wb_req & wb_ready
- mem_rdy  in  1  DRr holds valid memory read data
- mdu_busy  in  1  HI/LO update in progress
- MUX_GR_W_DATA  out  3  select for the GR write-data mux; 7 (NONE) when no write is pending
- gr_we  out  1  register-file write enable
- gr_waddr  out  5  register-file write address
- wb_done  out  1  one-cycle pulse: request completed
- wb_err  out  1  one-cycle pulse: illegal source or timeout
- stall_cnt  out  16  saturating count of cycles spent in WAIT

## Operation
- States: IDLE, WAIT, WRITE, ERR. Reset state is IDLE.
- Acceptance in IDLE latches wb_src into src_q and wb_rd into rd_q, and clears wait_cnt.
- Ready condition rdy(src):
  - DRr requires mem_rdy = 1.
  - HI and LO require mdu_busy = 0.
  - Z, PC and CLZ are always ready.
- Transitions out of IDLE on acceptance:
  - Illegal src (6 or 7) goes to ERR.
  - Otherwise, rdy evaluated in the acceptance cycle goes to WRITE.
  - Otherwise goes to WAIT.
- WAIT:
  - If rdy(src_q) is true, go to WRITE.
  - Otherwise, if wait_cnt == TIMEOUT_CYCLES-1, go to ERR.
  - Otherwise increment wait_cnt and stay in WAIT.
  - If rdy and the timeout occur in the same cycle, WRITE wins.
- WRITE:
  - gr_we = (rd_q != 0). A write to $0 is suppressed but still completes.
  - wb_done = 1.
  - Next state is IDLE.
- ERR: wb_err = 1, next state IDLE. No register write occurs.
- MUX_GR_W_DATA = src_q in WAIT and WRITE, so the mux is settled before the write; 7 in IDLE and ERR.
- gr_waddr = rd_q in WAIT and WRITE; 0 otherwise.
- stall_cnt increments once per cycle in WAIT, saturates at 16'hFFFF and is cleared only by rst.
- wb_req outside IDLE is ignored. The requester must hold wb_req, wb_src and wb_rd until wb_ready is seen.
- All outputs are registered or decoded from state and latched registers only. There is no combinational path from inputs to outputs.

## Timing
- Reset values:
  - state IDLE, wb_ready 1, MUX_GR_W_DATA 7
  - gr_we 0, gr_waddr 0, wb_done 0, wb_err 0, stall_cnt 0
  - src_q 7, rd_q 0, wait_cnt 0
- Latency with no stall: accept at cycle N; WRITE with gr_we and wb_done at N+1; wb_ready again at N+2.
- Latency with a stall: rdy first true at cycle M in WAIT gives WRITE at M+1.
- Timeout: ERR is reached after exactly TIMEOUT_CYCLES cycles in WAIT with rdy false throughout.
- Back-to-back requests: maximum throughput is one request per 2 cycles.
- Reset mid-operation: rst in any state returns to IDLE on the next edge. The pending write is dropped, no wb_done or wb_err pulse is issued, and stall_cnt is cleared.

## Test plan
- Reset, then wb_req with src 0 (Z) and rd 5 -> next cycle gr_we=1, gr_waddr=5, MUX_GR_W_DATA=0, wb_done=1; wb_ready=1 the cycle after.
- Src 2 (HI), rd 9, mdu_busy high for 3 cycles after acceptance -> 3 WAIT cycles, WRITE on the 4th cycle after acceptance, stall_cnt=3.
- Src 1 (DRr) with mem_rdy held low, TIMEOUT_CYCLES=64 -> wb_err pulse after 64 WAIT cycles, gr_we never asserted, stall_cnt=64.
- Src 4 (PC), rd 0 -> wb_done=1, gr_we=0. Separately, src 6 -> wb_err on the next cycle with MUX_GR_W_DATA=7.
- Src 3 (LO) in WAIT with rst asserted -> next cycle state IDLE, all outputs at reset values, no done or err pulse.
- In WAIT, mdu_busy drops in the same cycle wait_cnt reaches TIMEOUT_CYCLES-1 -> WRITE occurs and wb_err is not asserted.
